// File: rtl/mmio_timer_responder.sv
// Memory-mapped countdown timer on the M-stage word load/store bus.
// Registers: CTRL (EN/MODE/IM), PRESET, COUNT (read-only); irq on expiry.
module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // state     | meaning
  // ST_IDLE   | stopped, waiting for CTRL.EN
  // ST_LOAD   | copy PRESET into COUNT
  // ST_CNT    | decrement COUNT towards zero
  // ST_INT    | expiry: one-shot stops / auto-reload restarts
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;

  logic        hit;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        reload_mode;
  logic        one_shot_expiry;
  logic        unused_bits;

  assign en   = ctrl[0];
  assign mode = ctrl[2:1];
  assign im   = ctrl[3];

  // Only mode 1 auto-reloads; modes 0, 2 and 3 all act as one-shot.
  assign reload_mode     = (mode == 2'd1);
  assign one_shot_expiry = (state == ST_INT) && !reload_mode;

  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign ctrl_wr   = we && hit && (addr[3:2] == 2'd0);
  assign preset_wr = we && hit && (addr[3:2] == 2'd1);

  assign unused_bits = ^addr[1:0];

  always_comb begin
    rdata = 32'h0;
    if (hit) begin
      case (addr[3:2])
        2'd0:    rdata = {28'h0, ctrl};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = en ? ST_CNT : ST_IDLE;
      ST_CNT: begin
        if (!en)
          state_nxt = ST_IDLE;
        else if (count == 32'h0)
          state_nxt = ST_INT;
      end
      ST_INT:  state_nxt = (reload_mode && en) ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ctrl        <= 4'h0;
      preset      <= 32'h0;
      count       <= 32'h0;
      irq_pending <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_LOAD)
        count <= preset;
      else if ((state == ST_CNT) && en && (count != 32'h0))
        count <= count - 32'd1;

      // A CPU write to CTRL overrides the FSM clearing EN in the same cycle.
      if (ctrl_wr)
        ctrl <= wdata[3:0];
      else if (one_shot_expiry)
        ctrl[0] <= 1'b0;

      if (preset_wr)
        preset <= wdata;

      // Setting on expiry beats a simultaneous clearing CTRL write.
      if (one_shot_expiry)
        irq_pending <= 1'b1;
      else if (ctrl_wr)
        irq_pending <= 1'b0;
    end
  end

  assign irq = im && (irq_pending || (state == ST_INT));

endmodule
